pwm_duty_ctrl: RTL
==================

Name: pwm_duty_ctrl

Overview:
Duty-cycle controller that configures the pwm generator from the two user switches, swt_increase and swt_decrease, or from an automatic ramp sequencer. It synchronises and debounces the switches and saturates the duty level to 0..DUTY_MAX, so one unit equals 10% at the default. It presents new values to the pwm only at PWM period boundaries, giving glitch-free updates. It sits between the board switches and the pwm block's duty input.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a switch level is accepted (range 1..255).
DUTY_MAX, 10, maximum duty level; pwm period is DUTY_MAX+1 counts (maximum 15).
DUTY_INIT, 5, duty level after reset (must be <= DUTY_MAX).
DUTY_STEP, 1, amount added or subtracted per press or ramp step (range 1..DUTY_MAX).
RAMP_DIV, 4, number of pwm_period_end pulses between ramp steps (range 1..255).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
swt_increase  in  1  asynchronous switch, raw level
swt_decrease  in  1  asynchronous switch, raw level
mode_auto  in  1  synchronous; 1 selects ramp sequencing, 0 selects manual
pwm_period_end  in  1  one-cycle pulse from pwm when counter_PWM wraps
duty_level  out  4  duty value applied to pwm (registered)
duty_load  out  1  one-cycle strobe; duty_level changed on this cycle
at_max  out  1  duty_next == DUTY_MAX (combinational from register)
at_min  out  1  duty_next == 0
ctrl_state  out  2  0=MANUAL, 1=RAMP_UP, 2=RAMP_DOWN

Behaviour:
- Reset (rst=1 at a clk edge) has priority over all other activity, including mid-ramp and mid-debounce.
  - duty_level and duty_next are set to DUTY_INIT; pending=0; duty_load=0.
  - State returns to MANUAL.
  - Synchroniser flops, debounced levels, debounce counters and the ramp counter clear to 0.
- Synchroniser: 2 flops per switch.
- Debounce, per switch: the counter increments while the synced level differs from the debounced level and clears when they match. When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips on the next edge.
- Press pulse: asserted for one cycle on a rising edge of the debounced level. Releases generate nothing.
- Latency: duty_next updates 2+DEBOUNCE_CYCLES+1 edges after the first edge that samples a high switch (7 at defaults).
- Duty arithmetic is 5-bit with saturation:
  - inc: duty_next = min(duty_next+DUTY_STEP, DUTY_MAX).
  - dec: duty_next = max(duty_next-DUTY_STEP, 0), with no underflow wrap.
  - A press that produces no change does not set pending.
- MANUAL state:
  - An inc press alone increments; a dec press alone decrements.
  - Inc and dec presses in the same cycle are ignored.
  - mode_auto=1 moves to RAMP_DOWN if duty_next==DUTY_MAX, else to RAMP_UP, on the next edge. The ramp counter clears on entry.
- RAMP_UP / RAMP_DOWN states:
  - Switch presses are ignored, but debouncing continues.
  - Each pwm_period_end increments the ramp counter. When the counter reaches RAMP_DIV-1, it clears and duty_next steps by ±DUTY_STEP, saturating.
  - RAMP_UP goes to RAMP_DOWN on the step that reaches DUTY_MAX. RAMP_DOWN goes to RAMP_UP on the step that reaches 0.
  - mode_auto=0 returns to MANUAL on the next edge and holds duty_next. A pending value is still delivered.
- Update handshake to pwm:
  - pending is set when duty_next changes.
  - On an edge with pwm_period_end=1 and pending=1, duty_level takes the pre-edge duty_next, pending clears, and duty_load=1 for exactly that following cycle.
  - If duty_next changes on the same edge, for example a ramp step triggered by the same pwm_period_end, the new value stays pending for the next period.
  - When pwm_period_end=1 with pending=0, duty_level and duty_load are unchanged.
- duty_level never changes except at a pwm_period_end or reset.

Test Plan:
1. Reset, then hold swt_increase high for 10 clk, with pwm_period_end pulsing every 11 clk -> duty_next 5→6 exactly 7 edges after the first high sample. duty_level=6 and duty_load pulses one cycle after the next period_end. Only one step occurs per press.
2. Seven increase presses, each 10 clk high and 10 clk low -> duty_next saturates at 10 and at_max=1. The last two presses set no pending and cause no duty_load.
3. Glitch rejection: swt_decrease high for 3 clk, low for 2 clk, repeated -> no press pulse and duty_next unchanged.
4. Simultaneous presses: swt_increase and swt_decrease rise on the same edge for 10 clk -> no change to duty_next or pending.
5. Ramp: mode_auto=1 from duty 5 with RAMP_DIV=4 -> duty_next steps every 4 periods (6, 7, … 10). State changes to RAMP_DOWN at 10 and back to RAMP_UP at 0. Each duty_level update lags its step by one period.
6. Reset asserted mid-ramp at duty 8 with pending=1 -> on the next edge duty_level=5, ctrl_state=0, pending=0, duty_load=0, and no load at the next period_end.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller for the pwm block: debounced up/down switches or an
// automatic ramp set a saturating duty level that is handed over only at period ends.
module pwm_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DUTY_MAX        = 10,
  parameter int unsigned DUTY_INIT       = 5,
  parameter int unsigned DUTY_STEP       = 1,
  parameter int unsigned RAMP_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swt_increase,
  input  logic       swt_decrease,
  input  logic       mode_auto,
  input  logic       pwm_period_end,
  output logic [3:0] duty_level,
  output logic       duty_load,
  output logic       at_max,
  output logic       at_min,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
  localparam logic [4:0] MAX5      = 5'(DUTY_MAX);
  localparam logic [4:0] STEP5     = 5'(DUTY_STEP);
  localparam logic [3:0] MAX4      = 4'(DUTY_MAX);
  localparam logic [3:0] INIT4     = 4'(DUTY_INIT);

  // Bit 0 is the increase switch, bit 1 the decrease switch.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] deb_d;
  logic [1:0] press;
  logic [7:0] db_cnt [2];

  state_t     state_q;
  state_t     state_d;
  logic [3:0] duty_next_q;
  logic [3:0] duty_d;
  logic [7:0] ramp_q;
  logic [7:0] ramp_d;
  logic       pending;

  assign raw = {swt_decrease, swt_increase};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] d);
    logic [4:0] s;
    s = {1'b0, d} + STEP5;
    return (s > MAX5) ? MAX4 : s[3:0];
  endfunction

  // Clamp at zero instead of wrapping below it.
  function automatic logic [3:0] sat_dec(input logic [3:0] d);
    return ({1'b0, d} < STEP5) ? 4'd0 : 4'({1'b0, d} - STEP5);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= MANUAL;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_next_q;
    ramp_d  = ramp_q;
    case (state_q)
      MANUAL: begin
        if (press[0] && !press[1])      duty_d = sat_inc(duty_next_q);
        else if (press[1] && !press[0]) duty_d = sat_dec(duty_next_q);
        if (mode_auto) begin
          state_d = (duty_next_q == MAX4) ? RAMP_DOWN : RAMP_UP;
          ramp_d  = '0;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (!mode_auto) begin
          state_d = MANUAL;
        end else if (pwm_period_end) begin
          if (ramp_q == RAMP_LAST) begin
            ramp_d = '0;
            if (state_q == RAMP_UP) begin
              duty_d = sat_inc(duty_next_q);
              if (duty_d == MAX4) state_d = RAMP_DOWN;
            end else begin
              duty_d = sat_dec(duty_next_q);
              if (duty_d == 4'd0) state_d = RAMP_UP;
            end
          end else begin
            ramp_d = ramp_q + 8'd1;
          end
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  // A change on the same edge as a hand-over stays pending for the next period.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_next_q <= INIT4;
      ramp_q      <= '0;
      duty_level  <= INIT4;
      duty_load   <= 1'b0;
      pending     <= 1'b0;
    end else begin
      duty_next_q <= duty_d;
      ramp_q      <= ramp_d;
      duty_load   <= pwm_period_end & pending;
      if (pwm_period_end && pending) duty_level <= duty_next_q;
      if (duty_d != duty_next_q) pending <= 1'b1;
      else if (pwm_period_end)   pending <= 1'b0;
    end
  end

  always_comb begin
    ctrl_state = state_q;
    at_max     = (duty_next_q == MAX4);
    at_min     = (duty_next_q == 4'd0);
  end

endmodule
